// File: rtl/gated_pipe_pkg.sv
// ---------------------------------------------------------------------------
// gated_pipe_pkg
// Shared definitions for the gated elastic pipeline:
//   - STATS_W      : width of the optional statistics counters
//   - stage_hs_t   : per-stage handshake bundle {valid, ready, ce}
//   - idle_cnt_w() : width of the idle counter able to hold IDLE_CYCLES
// ---------------------------------------------------------------------------
package gated_pipe_pkg;

    localparam int STATS_W = 32;

    typedef struct packed {
        logic valid;
        logic ready;
        logic ce;
    } stage_hs_t;

    // The idle counter saturates at IDLE_CYCLES, so it needs enough bits
    // to represent that value itself, not just IDLE_CYCLES-1.
    function automatic int idle_cnt_w(input int idleCycles);
        return $clog2(idleCycles + 1);
    endfunction

endpackage

// File: rtl/gated_pipe_stage.sv
// ---------------------------------------------------------------------------
// gated_pipe_stage
// One elastic register slot of the gated pipeline. Holds a valid bit and a
// data word; loads prevData + STAGE_INC whenever its clock-enable fires.
//
// Ports:
//   clk          : clock
//   rst          : synchronous active-high reset
//   i_enable     : global pipeline enable (0 freezes the slot)
//   i_flush      : synchronous clear of the valid bit
//   i_prevValid  : valid of the upstream slot (or producer)
//   i_prevData   : data of the upstream slot (or producer)
//   i_nextReady  : ready of the downstream slot (or consumer)
//   o_hs         : {valid, ready, ce} of this slot
//   o_data       : registered data of this slot
// ---------------------------------------------------------------------------
module gated_pipe_stage
    import gated_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STAGE_INC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_prevValid,
    input  logic [WIDTH-1:0] i_prevData,
    input  logic             i_nextReady,
    output stage_hs_t        o_hs,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [WIDTH-1:0] INC = WIDTH'(STAGE_INC);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_ready;
    logic             w_ce;

    // A slot can take a new word when it is empty or when its current word
    // is leaving this cycle. The load enable is suppressed during reset and
    // flush so the exported ICG enable never pulses in those cycles.
    assign w_ready = !r_valid || i_nextReady;
    assign w_ce    = i_enable && !i_flush && !rst && i_prevValid && w_ready;

    // Valid tracking: flush always wins, a load sets valid, and a word that
    // drains downstream without a replacement leaves a bubble. The data
    // register only moves on its clock-enable, so a gated clock is safe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_ce) begin
                r_valid <= 1'b1;
            end else if (i_nextReady && i_enable) begin
                r_valid <= 1'b0;
            end
            if (w_ce) begin
                r_data <= i_prevData + INC;
            end
        end
    end

    assign o_hs.valid = r_valid;
    assign o_hs.ready = w_ready;
    assign o_hs.ce    = w_ce;
    assign o_data     = r_data;

endmodule

// File: rtl/gated_elastic_pipeline.sv
// ---------------------------------------------------------------------------
// gated_elastic_pipeline
// Elastic valid/ready pipeline of STAGES slots, each adding STAGE_INC.
// Exports per-stage clock-enables for ICG insertion and an idle flag for
// block-level power gating.
//
// Optional feature macro: GATED_PIPE_STATS_EN adds xfer_count, stall_count
// and gated_cycles statistics outputs.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pipeline_en  : global enable, 0 freezes every stage
//   flush        : clears every stage valid on the next edge
//   in_valid/in_ready/in_data    : producer side handshake
//   out_valid/out_ready/out_data : consumer side handshake
//   stage_ce     : per-stage load enable (ICG enable)
//   idle         : pipe empty with no input for IDLE_CYCLES cycles
//   xfer_count, stall_count, gated_cycles : statistics (macro only)
// ---------------------------------------------------------------------------
module gated_elastic_pipeline
    import gated_pipe_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int STAGES      = 4,
    parameter int STAGE_INC   = 1,
    parameter int IDLE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipeline_en,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAGES-1:0] stage_ce,
    output logic              idle
`ifdef GATED_PIPE_STATS_EN
    ,
    output logic [STATS_W-1:0] xfer_count,
    output logic [STATS_W-1:0] stall_count,
    output logic [STATS_W-1:0] gated_cycles
`endif
);

    localparam int                IDLE_W   = idle_cnt_w(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);

    logic [STAGES-1:0] w_stageValid;
    logic              w_empty;
    logic [IDLE_W-1:0] r_idleCount;

    // Stage chain: each slot looks back at its upstream neighbour for
    // valid/data and forward at its downstream neighbour for ready. The
    // first slot is fed by the producer and the last by the consumer.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        stage_hs_t        w_hs;
        logic [WIDTH-1:0] w_data;
        logic             w_prevValid;
        logic [WIDTH-1:0] w_prevData;
        logic             w_nextReady;

        if (i == 0) begin : g_head
            assign w_prevValid = in_valid;
            assign w_prevData  = in_data;
        end else begin : g_body
            assign w_prevValid = g_stage[i-1].w_hs.valid;
            assign w_prevData  = g_stage[i-1].w_data;
        end

        if (i == STAGES - 1) begin : g_tail
            assign w_nextReady = out_ready;
        end else begin : g_link
            assign w_nextReady = g_stage[i+1].w_hs.ready;
        end

        gated_pipe_stage #(
            .WIDTH     (WIDTH),
            .STAGE_INC (STAGE_INC)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .i_enable    (pipeline_en),
            .i_flush     (flush),
            .i_prevValid (w_prevValid),
            .i_prevData  (w_prevData),
            .i_nextReady (w_nextReady),
            .o_hs        (w_hs),
            .o_data      (w_data)
        );

        assign w_stageValid[i] = w_hs.valid;
        assign stage_ce[i]     = w_hs.ce;
    end

    // The producer is only told "ready" when the pipe is running and not
    // being flushed or reset, so nothing is accepted that would be dropped.
    assign in_ready  = pipeline_en && !flush && !rst && g_stage[0].w_hs.ready;
    assign out_valid = pipeline_en && !rst && g_stage[STAGES-1].w_hs.valid;
    assign out_data  = g_stage[STAGES-1].w_data;

    // Idle detection: count consecutive cycles with an empty pipe and no
    // incoming word, saturating at IDLE_CYCLES. The flag is also qualified
    // combinationally so it drops in the very cycle in_valid rises.
    assign w_empty = !(|w_stageValid) && !in_valid;
    assign idle    = (r_idleCount == IDLE_MAX) && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idleCount <= '0;
        end else if (!w_empty) begin
            r_idleCount <= '0;
        end else if (r_idleCount != IDLE_MAX) begin
            r_idleCount <= r_idleCount + 1'b1;
        end
    end

`ifdef GATED_PIPE_STATS_EN
    logic [STATS_W-1:0] r_xferCount;
    logic [STATS_W-1:0] r_stallCount;
    logic [STATS_W-1:0] r_gatedCycles;

    // Free-running wrapping statistics, cleared only by reset: completed
    // output transfers, cycles the consumer stalled a valid word, and
    // cycles in which every stage clock was gated off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xferCount   <= '0;
            r_stallCount  <= '0;
            r_gatedCycles <= '0;
        end else begin
            if (out_valid && out_ready) begin
                r_xferCount <= r_xferCount + 1'b1;
            end
            if (out_valid && !out_ready) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
            if (stage_ce == '0) begin
                r_gatedCycles <= r_gatedCycles + 1'b1;
            end
        end
    end

    assign xfer_count   = r_xferCount;
    assign stall_count  = r_stallCount;
    assign gated_cycles = r_gatedCycles;
`endif

endmodule

// File: tb/tb_gated_elastic_pipeline.sv
// ---------------------------------------------------------------------------
// tb_gated_elastic_pipeline
// Directed bench for gated_elastic_pipeline with STAGES=4, STAGE_INC=1,
// IDLE_CYCLES=8. A per-cycle vector table covers the no-stall stream and
// wrap-around; hand-written sequences cover stall, freeze, flush, idle and
// mid-stream reset. Statistics checks are built when GATED_PIPE_STATS_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_gated_elastic_pipeline;

    localparam int WIDTH       = 32;
    localparam int STAGES      = 4;
    localparam int STAGE_INC   = 1;
    localparam int IDLE_CYCLES = 8;
    localparam int NVEC        = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipeline_en;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [STAGES-1:0] stage_ce;
    logic              idle;
`ifdef GATED_PIPE_STATS_EN
    logic [31:0]       xfer_count;
    logic [31:0]       stall_count;
    logic [31:0]       gated_cycles;
`endif

    typedef struct {
        logic        inValid;
        logic [31:0] inData;
        logic        expInReady;
        logic        expOutValid;
        logic [31:0] expOutData;
        logic [3:0]  expCe;
        logic        expIdle;
    } vec_t;

    vec_t vecs [NVEC];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gated_elastic_pipeline #(
        .WIDTH       (WIDTH),
        .STAGES      (STAGES),
        .STAGE_INC   (STAGE_INC),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipeline_en  (pipeline_en),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .stage_ce     (stage_ce),
        .idle         (idle)
`ifdef GATED_PIPE_STATS_EN
        ,
        .xfer_count   (xfer_count),
        .stall_count  (stall_count),
        .gated_cycles (gated_cycles)
`endif
    );

    // Drives all producer/consumer/control inputs for the coming cycle.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic rdy, input logic en,
                                 input logic fl);
        in_valid    = v;
        in_data     = d;
        out_ready   = rdy;
        pipeline_en = en;
        flush       = fl;
    endtask

    // One comparison against a bench-computed expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records a beat accepted in cycle b with no stalls: stage i loads it in
    // cycle b+i and it is presented at the output in cycle b+STAGES.
    task automatic addBeat(input int b, input logic [31:0] d);
        vecs[b].inValid = 1'b1;
        vecs[b].inData  = d;
        for (int i = 0; i < STAGES; i++) begin
            vecs[b+i].expCe[i] = 1'b1;
        end
        vecs[b+STAGES].expOutValid = 1'b1;
        vecs[b+STAGES].expOutData  = d + 32'd4;
    endtask

    initial begin
        for (int k = 0; k < NVEC; k++) begin
            vecs[k].inValid     = 1'b0;
            vecs[k].inData      = 32'd0;
            vecs[k].expInReady  = 1'b1;
            vecs[k].expOutValid = 1'b0;
            vecs[k].expOutData  = 32'd0;
            vecs[k].expCe       = 4'b0000;
            vecs[k].expIdle     = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            addBeat(k, 32'(k));
        end
        addBeat(16, 32'hFFFF_FFFE);
        addBeat(17, 32'hFFFF_FFFF);

        rst = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        step();
        step();
        @(negedge clk);
        checkOutput("rst in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst out_data", out_data, 32'd0);
        checkOutput("rst stage_ce", 32'(stage_ce), 32'd0);
        checkOutput("rst idle", 32'(idle), 32'd0);
        step();
        rst = 1'b0;

        // Back-to-back stream and wrap-around from the vector table.
        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(vecs[k].inValid, vecs[k].inData, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d in_ready", k), 32'(in_ready), 32'(vecs[k].expInReady));
            checkOutput($sformatf("tbl%0d out_valid", k), 32'(out_valid), 32'(vecs[k].expOutValid));
            if (vecs[k].expOutValid) begin
                checkOutput($sformatf("tbl%0d out_data", k), out_data, vecs[k].expOutData);
            end
            checkOutput($sformatf("tbl%0d stage_ce", k), 32'(stage_ce), 32'(vecs[k].expCe));
            checkOutput($sformatf("tbl%0d idle", k), 32'(idle), 32'(vecs[k].expIdle));
            step();
        end

        // Fill the pipe against a stalled consumer; bubbles collapse.
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b1, 32'(100 + j), 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("fill%0d in_ready", j), 32'(in_ready), 32'd1);
            if (j == 3) begin
                checkOutput("fill3 stage_ce", 32'(stage_ce), 32'hF);
            end
            step();
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b1, 32'd104, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("stall%0d in_ready", j), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall%0d stage_ce", j), 32'(stage_ce), 32'd0);
            checkOutput($sformatf("stall%0d out_valid", j), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d out_data", j), out_data, 32'd104);
            step();
        end
        applyStimulus(1'b1, 32'd104, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("release in_ready", 32'(in_ready), 32'd1);
        checkOutput("release out_data", out_data, 32'd104);
        step();
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("drain%0d out_valid", j), 32'(out_valid), 32'd1);
            checkOutput($sformatf("drain%0d out_data", j), out_data, 32'(105 + j));
            step();
        end
        @(negedge clk);
        checkOutput("drained out_valid", 32'(out_valid), 32'd0);
`ifdef GATED_PIPE_STATS_EN
        checkOutput("stats stall_count", stall_count, 32'd5);
        checkOutput("stats xfer_count", xfer_count, 32'd17);
`endif
        step();

        // Freeze for three cycles mid-stream, then resume.
        applyStimulus(1'b1, 32'd200, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 32'd201, 1'b1, 1'b1, 1'b0);
        step();
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, 32'd202, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("frz%0d out_valid", j), 32'(out_valid), 32'd0);
            checkOutput($sformatf("frz%0d stage_ce", j), 32'(stage_ce), 32'd0);
            checkOutput($sformatf("frz%0d in_ready", j), 32'(in_ready), 32'd0);
            checkOutput($sformatf("frz%0d out_data", j), out_data, 32'd108);
            step();
        end
        applyStimulus(1'b1, 32'd202, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("resume in_ready", 32'(in_ready), 32'd1);
        step();
        applyStimulus(1'b1, 32'd203, 1'b1, 1'b1, 1'b0);
        step();
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("resume%0d out_valid", j), 32'(out_valid), 32'd1);
            checkOutput($sformatf("resume%0d out_data", j), out_data, 32'(204 + j));
            step();
        end
        @(negedge clk);
        checkOutput("resumed out_valid", 32'(out_valid), 32'd0);

        // Flush a half-full pipe together with an incoming word.
        applyStimulus(1'b1, 32'd300, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 32'd301, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 32'd302, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("flush in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush stage_ce", 32'(stage_ce), 32'd0);
        step();
        for (int j = 0; j < 8; j++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("postflush%0d out_valid", j), 32'(out_valid), 32'd0);
            checkOutput($sformatf("postflush%0d idle", j), 32'(idle), 32'd0);
            if (j == 0) begin
                checkOutput("postflush out_data", out_data, 32'd207);
            end
            step();
        end
        @(negedge clk);
        checkOutput("idle asserted", 32'(idle), 32'd1);
        step();
        applyStimulus(1'b1, 32'd400, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("idle drop", 32'(idle), 32'd0);
        @(negedge clk);
        checkOutput("idle drop in_ready", 32'(in_ready), 32'd1);
        step();

        // Flush while frozen still discards the accepted word.
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("frzflush stage_ce", 32'(stage_ce), 32'd0);
        step();
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("frzflush%0d out_valid", j), 32'(out_valid), 32'd0);
            step();
        end

        // Reset in the middle of a stream discards everything in flight.
        applyStimulus(1'b1, 32'd500, 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 32'd501, 1'b1, 1'b1, 1'b0);
        step();
        rst = 1'b1;
        applyStimulus(1'b1, 32'd502, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst stage_ce", 32'(stage_ce), 32'd0);
        checkOutput("midrst idle", 32'(idle), 32'd0);
        step();
        @(negedge clk);
        checkOutput("midrst out_data", out_data, 32'd0);
`ifdef GATED_PIPE_STATS_EN
        checkOutput("midrst xfer_count", xfer_count, 32'd0);
`endif
        step();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("afterrst%0d out_valid", j), 32'(out_valid), 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
